// File: rtl/rvx_core_trap_csr_if.sv
// Stage-1 trap/CSR bus between the pipeline (master) and the machine-mode trap CSR file (slave).
interface rvx_core_trap_csr_if;
  logic        stall_s1;
  logic        take_trap_s1;
  logic        mret_s1;
  logic        illegal_instruction_s1;
  logic        misaligned_instruction_address_s1;
  logic        ecall_s1;
  logic        ebreak_s1;
  logic        misaligned_load_s1;
  logic        misaligned_store_s1;
  logic        irq_external;
  logic        irq_timer;
  logic        irq_software;
  logic [31:0] pc_s1;
  logic [31:0] instruction_s1;
  logic [31:0] target_address_s1;
  logic [31:0] data_address_s1;
  logic        csr_write_enable_s1;
  logic [11:0] csr_address_s1;
  logic [31:0] csr_write_data_s1;
  logic [31:0] csr_read_data_s1;
  logic        global_interrupt_enable_s1;
  logic        interrupt_pending_s1;
  logic [31:0] trap_address_s1;

  modport master (
    output stall_s1, take_trap_s1, mret_s1,
           illegal_instruction_s1, misaligned_instruction_address_s1, ecall_s1, ebreak_s1,
           misaligned_load_s1, misaligned_store_s1,
           irq_external, irq_timer, irq_software,
           pc_s1, instruction_s1, target_address_s1, data_address_s1,
           csr_write_enable_s1, csr_address_s1, csr_write_data_s1,
    input  csr_read_data_s1, global_interrupt_enable_s1, interrupt_pending_s1, trap_address_s1
  );

  modport slave (
    input  stall_s1, take_trap_s1, mret_s1,
           illegal_instruction_s1, misaligned_instruction_address_s1, ecall_s1, ebreak_s1,
           misaligned_load_s1, misaligned_store_s1,
           irq_external, irq_timer, irq_software,
           pc_s1, instruction_s1, target_address_s1, data_address_s1,
           csr_write_enable_s1, csr_address_s1, csr_write_data_s1,
    output csr_read_data_s1, global_interrupt_enable_s1, interrupt_pending_s1, trap_address_s1
  );
endinterface

// File: rtl/rvx_core_trap_csr.sv
// Machine-mode trap CSR file: cause selection, trap/mret state update and redirect address.
// Optional vectored mtvec mode is enabled with `define RVX_VECTORED_MTVEC_EN.
module rvx_core_trap_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input logic                  clock,
  input logic                  reset_n,
  rvx_core_trap_csr_if.slave   bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [2:0]  mie_q;        // {MEIE, MTIE, MSIE}
  logic [2:0]  mip_q;        // {MEIP, MTIP, MSIP}
  logic [31:2] mtvec_base;
`ifdef RVX_VECTORED_MTVEC_EN
  logic        mtvec_mode;
`endif
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;

  logic [31:0] mstatus_word;
  logic [31:0] mie_word;
  logic [31:0] mip_word;
  logic [31:0] mtvec_word;
  logic [2:0]  irq_active;
  logic        irq_selected;
  logic [31:0] sel_cause;
  logic [31:0] sel_tval;
  logic [31:0] trap_base;
  logic        trap_en;
  logic        mret_en;
  logic        csr_we;

  assign mstatus_word = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mie_word     = {20'b0, mie_q[2], 3'b0, mie_q[1], 3'b0, mie_q[0], 3'b0};
  assign mip_word     = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};
`ifdef RVX_VECTORED_MTVEC_EN
  assign mtvec_word   = {mtvec_base, 1'b0, mtvec_mode};
`else
  assign mtvec_word   = {mtvec_base, 2'b00};
`endif
  assign trap_base    = {mtvec_base, 2'b00};

  assign irq_active   = mip_q & mie_q;
  assign irq_selected = mstatus_mie & (|irq_active);

  assign bus.global_interrupt_enable_s1 = mstatus_mie;
  assign bus.interrupt_pending_s1       = |irq_active;

  assign trap_en = bus.take_trap_s1 & ~bus.stall_s1;
  assign mret_en = bus.mret_s1 & ~bus.stall_s1 & ~bus.take_trap_s1;
  assign csr_we  = bus.csr_write_enable_s1 & ~bus.stall_s1 & ~bus.take_trap_s1 & ~bus.mret_s1;

  // Interrupts override exceptions; interrupt order is MEI > MSI > MTI.
  always_comb begin
    sel_cause = '0;
    sel_tval  = '0;
    if (irq_selected) begin
      if (irq_active[2])      sel_cause = 32'h8000_000B;
      else if (irq_active[0]) sel_cause = 32'h8000_0003;
      else                    sel_cause = 32'h8000_0007;
    end else if (bus.illegal_instruction_s1) begin
      sel_cause = 32'd2;
      sel_tval  = bus.instruction_s1;
    end else if (bus.misaligned_instruction_address_s1) begin
      sel_cause = 32'd0;
      sel_tval  = bus.target_address_s1;
    end else if (bus.ecall_s1) begin
      sel_cause = 32'd11;
    end else if (bus.ebreak_s1) begin
      sel_cause = 32'd3;
    end else if (bus.misaligned_load_s1) begin
      sel_cause = 32'd4;
      sel_tval  = bus.data_address_s1;
    end else if (bus.misaligned_store_s1) begin
      sel_cause = 32'd6;
      sel_tval  = bus.data_address_s1;
    end
  end

  always_comb begin
    bus.trap_address_s1 = trap_base;
    if (bus.mret_s1 && !bus.take_trap_s1) begin
      bus.trap_address_s1 = mepc;
    end
`ifdef RVX_VECTORED_MTVEC_EN
    else if (mtvec_mode && irq_selected) begin
      bus.trap_address_s1 = trap_base + {26'b0, sel_cause[3:0], 2'b00};
    end
`endif
  end

  always_comb begin
    bus.csr_read_data_s1 = '0;
    case (bus.csr_address_s1)
      ADDR_MSTATUS:  bus.csr_read_data_s1 = mstatus_word;
      ADDR_MISA:     bus.csr_read_data_s1 = MISA_VALUE;
      ADDR_MIE:      bus.csr_read_data_s1 = mie_word;
      ADDR_MTVEC:    bus.csr_read_data_s1 = mtvec_word;
      ADDR_MSCRATCH: bus.csr_read_data_s1 = mscratch;
      ADDR_MEPC:     bus.csr_read_data_s1 = mepc;
      ADDR_MCAUSE:   bus.csr_read_data_s1 = mcause;
      ADDR_MTVAL:    bus.csr_read_data_s1 = mtval;
      ADDR_MIP:      bus.csr_read_data_s1 = mip_word;
      default:       bus.csr_read_data_s1 = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_base   <= RESET_MTVEC[31:2];
`ifdef RVX_VECTORED_MTVEC_EN
      mtvec_mode   <= RESET_MTVEC[0];
`endif
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      // mip tracks the irq lines even while stalled.
      mip_q <= {bus.irq_external, bus.irq_timer, bus.irq_software};
      if (trap_en) begin
        mepc         <= {bus.pc_s1[31:2], 2'b00};
        mcause       <= sel_cause;
        mtval        <= sel_tval;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_en) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_we) begin
        case (bus.csr_address_s1)
          ADDR_MSTATUS: begin
            mstatus_mie  <= bus.csr_write_data_s1[3];
            mstatus_mpie <= bus.csr_write_data_s1[7];
          end
          ADDR_MIE: mie_q <= {bus.csr_write_data_s1[11], bus.csr_write_data_s1[7],
                              bus.csr_write_data_s1[3]};
          ADDR_MTVEC: begin
            mtvec_base <= bus.csr_write_data_s1[31:2];
`ifdef RVX_VECTORED_MTVEC_EN
            mtvec_mode <= bus.csr_write_data_s1[0];
`endif
          end
          ADDR_MSCRATCH: mscratch <= bus.csr_write_data_s1;
          ADDR_MEPC:     mepc     <= {bus.csr_write_data_s1[31:2], 2'b00};
          ADDR_MCAUSE:   mcause   <= bus.csr_write_data_s1;
          ADDR_MTVAL:    mtval    <= bus.csr_write_data_s1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rvx_core_trap_csr.sv
// Self-checking bench for rvx_core_trap_csr: directed scenarios then randomized traffic vs. a CSR-level model.
module tb_rvx_core_trap_csr;

  localparam logic [31:0] RST_TVEC = 32'h0000_0100;
`ifdef RVX_VECTORED_MTVEC_EN
  localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] VEC_EXP   = 32'h0000_032C;
`else
  localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] VEC_EXP   = 32'h0000_0300;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rvx_core_trap_csr_if bus ();

  rvx_core_trap_csr #(.RESET_MTVEC(RST_TVEC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Model holds each CSR as the value software would read back.
  logic [31:0] m_status, m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval;

  task automatic m_reset();
    m_status  = 32'h0000_1800;
    m_ie      = '0;
    m_ip      = '0;
    m_tvec    = RST_TVEC & TVEC_MASK;
    m_scratch = '0;
    m_epc     = '0;
    m_cause   = '0;
    m_tval    = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_status;
      12'h301: return 32'h4000_0100;
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h340: return m_scratch;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h343: return m_tval;
      12'h344: return m_ip;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_select(output bit intr, output logic [31:0] cause, output logic [31:0] tval);
    logic [31:0] pend;
    bit          exc [6];
    logic [31:0] ecause [6];
    logic [31:0] etval [6];
    bit          found;
    pend   = m_ip & m_ie;
    intr   = m_status[3] && (pend != 0);
    cause  = '0;
    tval   = '0;
    exc    = '{bus.illegal_instruction_s1, bus.misaligned_instruction_address_s1, bus.ecall_s1,
               bus.ebreak_s1, bus.misaligned_load_s1, bus.misaligned_store_s1};
    ecause = '{32'd2, 32'd0, 32'd11, 32'd3, 32'd4, 32'd6};
    etval  = '{bus.instruction_s1, bus.target_address_s1, 32'd0, 32'd0,
               bus.data_address_s1, bus.data_address_s1};
    found  = 1'b0;
    if (intr) begin
      if (pend[11])     cause = 32'h8000_000B;
      else if (pend[3]) cause = 32'h8000_0003;
      else              cause = 32'h8000_0007;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!found && exc[i]) begin
          cause = ecause[i];
          tval  = etval[i];
          found = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] m_trap_addr();
    bit          intr;
    logic [31:0] c, t, base;
    m_select(intr, c, t);
    if (bus.mret_s1 && !bus.take_trap_s1) return m_epc;
    base = m_tvec & 32'hFFFF_FFFC;
    if (intr && m_tvec[0]) return base + ((c & 32'hF) << 2);
    return base;
  endfunction

  task automatic m_edge();
    bit          intr;
    logic [31:0] c, t, new_ip;
    if (!reset_n) begin
      m_reset();
    end else begin
      m_select(intr, c, t);
      new_ip = (bus.irq_external ? 32'h800 : 32'h0) | (bus.irq_timer ? 32'h80 : 32'h0)
             | (bus.irq_software ? 32'h8 : 32'h0);
      if (!bus.stall_s1) begin
        if (bus.take_trap_s1) begin
          m_epc    = bus.pc_s1 & 32'hFFFF_FFFC;
          m_cause  = c;
          m_tval   = t;
          m_status = 32'h1800 | (m_status[3] ? 32'h80 : 32'h0);
        end else if (bus.mret_s1) begin
          m_status = 32'h1880 | (m_status[7] ? 32'h8 : 32'h0);
        end else if (bus.csr_write_enable_s1) begin
          case (bus.csr_address_s1)
            12'h300: m_status  = 32'h1800 | (bus.csr_write_data_s1 & 32'h88);
            12'h304: m_ie      = bus.csr_write_data_s1 & 32'h888;
            12'h305: m_tvec    = bus.csr_write_data_s1 & TVEC_MASK;
            12'h340: m_scratch = bus.csr_write_data_s1;
            12'h341: m_epc     = bus.csr_write_data_s1 & 32'hFFFF_FFFC;
            12'h342: m_cause   = bus.csr_write_data_s1;
            12'h343: m_tval    = bus.csr_write_data_s1;
            default: ;
          endcase
        end
      end
      m_ip = new_ip;
    end
  endtask

  task automatic clear_ctl();
    bus.stall_s1 = 0; bus.take_trap_s1 = 0; bus.mret_s1 = 0;
    bus.illegal_instruction_s1 = 0; bus.misaligned_instruction_address_s1 = 0;
    bus.ecall_s1 = 0; bus.ebreak_s1 = 0; bus.misaligned_load_s1 = 0; bus.misaligned_store_s1 = 0;
    bus.pc_s1 = '0; bus.instruction_s1 = '0; bus.target_address_s1 = '0; bus.data_address_s1 = '0;
    bus.csr_write_enable_s1 = 0; bus.csr_address_s1 = '0; bus.csr_write_data_s1 = '0;
  endtask

  // Inputs are set just after a falling edge; check, clock, then advance the model.
  task automatic step();
    #1;
    check("rdata", bus.csr_read_data_s1, m_read(bus.csr_address_s1));
    check("gie", {31'b0, bus.global_interrupt_enable_s1}, {31'b0, m_status[3]});
    check("pend", {31'b0, bus.interrupt_pending_s1}, {31'b0, (m_ip & m_ie) != 0});
    check("trap_addr", bus.trap_address_s1, m_trap_addr());
    @(posedge clock);
    m_edge();
    @(negedge clock);
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
    clear_ctl();
    bus.csr_address_s1 = a;
    #1;
    check(tag, bus.csr_read_data_s1, exp);
    @(posedge clock);
    m_edge();
    @(negedge clock);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    clear_ctl();
    bus.csr_write_enable_s1 = 1;
    bus.csr_address_s1      = a;
    bus.csr_write_data_s1   = d;
    step();
  endtask

  initial begin
    bit          intr;
    bit          any_exc;
    logic [31:0] c, t;
    logic [11:0] addrs [9];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};

    clear_ctl();
    bus.irq_external = 0; bus.irq_timer = 0; bus.irq_software = 0;
    reset_n = 0;
    m_reset();
    @(negedge clock);
    step();
    step();
    reset_n = 1;

    rd(12'h305, "mtvec_reset", 32'h100);
    rd(12'h300, "mstatus_reset", 32'h1800);
    #1;
    check("gie_reset", {31'b0, bus.global_interrupt_enable_s1}, 32'h0);
    check("pend_reset", {31'b0, bus.interrupt_pending_s1}, 32'h0);

    wr(12'h304, 32'hFFFF_FFFF);
    wr(12'h300, 32'h8);
    rd(12'h304, "mie_readback", 32'h888);

    clear_ctl();
    bus.irq_timer = 1;
    #1;
    check("pend_before_sample", {31'b0, bus.interrupt_pending_s1}, 32'h0);
    step();
    check("pend_after_sample", {31'b0, bus.interrupt_pending_s1}, 32'h1);

    clear_ctl();
    bus.take_trap_s1 = 1;
    bus.pc_s1        = 32'h204;
    step();
    rd(12'h342, "mcause_mti", 32'h8000_0007);
    rd(12'h341, "mepc_mti", 32'h204);
    rd(12'h300, "mstatus_trap", 32'h1880);

    clear_ctl();
    bus.mret_s1 = 1;
    #1;
    check("mret_target", bus.trap_address_s1, 32'h204);
    step();
    rd(12'h300, "mstatus_mret", 32'h1888);

    bus.irq_timer = 0;
    clear_ctl();
    step();
    step();

    clear_ctl();
    bus.illegal_instruction_s1 = 1;
    bus.instruction_s1         = 32'hFFFF_FFFF;
    bus.ecall_s1               = 1;
    bus.take_trap_s1           = 1;
    step();
    rd(12'h342, "mcause_illegal", 32'h2);
    rd(12'h343, "mtval_illegal", 32'hFFFF_FFFF);

    wr(12'h340, 32'h1234_5678);
    clear_ctl();
    bus.take_trap_s1        = 1;
    bus.mret_s1             = 1;
    bus.ecall_s1            = 1;
    bus.csr_write_enable_s1 = 1;
    bus.csr_address_s1      = 12'h340;
    bus.csr_write_data_s1   = 32'hDEAD_BEEF;
    step();
    rd(12'h340, "mscratch_kept", 32'h1234_5678);
    #1;
    check("mie_after_collision", {31'b0, bus.global_interrupt_enable_s1}, 32'h0);

    wr(12'h305, 32'h301);
    wr(12'h304, 32'h800);
    wr(12'h300, 32'h8);
    clear_ctl();
    bus.irq_external = 1;
    step();
    #1;
    check("mei_target", bus.trap_address_s1, VEC_EXP);
    bus.take_trap_s1 = 1;
    step();
    rd(12'h342, "mcause_mei", 32'h8000_000B);
    bus.irq_external = 0;

    for (int n = 0; n < 2000; n++) begin
      reset_n          = ($urandom_range(0, 99) != 0);
      bus.stall_s1     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) bus.irq_external = ~bus.irq_external;
      if ($urandom_range(0, 15) == 0) bus.irq_timer    = ~bus.irq_timer;
      if ($urandom_range(0, 15) == 0) bus.irq_software = ~bus.irq_software;
      bus.illegal_instruction_s1            = ($urandom_range(0, 5) == 0);
      bus.misaligned_instruction_address_s1 = ($urandom_range(0, 5) == 0);
      bus.ecall_s1                          = ($urandom_range(0, 5) == 0);
      bus.ebreak_s1                         = ($urandom_range(0, 5) == 0);
      bus.misaligned_load_s1                = ($urandom_range(0, 5) == 0);
      bus.misaligned_store_s1               = ($urandom_range(0, 5) == 0);
      bus.pc_s1             = $urandom;
      bus.instruction_s1    = $urandom;
      bus.target_address_s1 = $urandom;
      bus.data_address_s1   = $urandom;
      if ($urandom_range(0, 3) == 0) bus.csr_address_s1 = 12'($urandom_range(0, 4095));
      else                           bus.csr_address_s1 = addrs[$urandom_range(0, 8)];
      bus.csr_write_enable_s1 = ($urandom_range(0, 2) == 0);
      bus.csr_write_data_s1   = $urandom;
      bus.mret_s1             = ($urandom_range(0, 7) == 0);
      m_select(intr, c, t);
      any_exc = bus.illegal_instruction_s1 | bus.misaligned_instruction_address_s1 | bus.ecall_s1
              | bus.ebreak_s1 | bus.misaligned_load_s1 | bus.misaligned_store_s1;
      bus.take_trap_s1 = (intr || any_exc) && ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rvx_core_trap_csr.md
# rvx_core_trap_csr

Machine-mode trap CSR file for the RVX core, upstream of the stage-1 trap decision. Holds mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval and misa. Supplies `global_interrupt_enable_s1` and `interrupt_pending_s1` to the trap-decision logic, consumes its `take_trap_s1` result to record trap state, and produces the redirect address for trap entry and `mret`.

## Interface
- `RESET_MTVEC`, 32'h00000000, reset value of mtvec (BASE and MODE together).
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `stall_s1` input 1: when high, no register updates except mip sampling.
- `take_trap_s1` input 1: trap taken this cycle.
- `mret_s1` input 1: `mret` retiring this cycle.
- `illegal_instruction_s1`, `misaligned_instruction_address_s1`, `ecall_s1`, `ebreak_s1`, `misaligned_load_s1`, `misaligned_store_s1` input 1 each: exception sources.
- `irq_external`, `irq_timer`, `irq_software` input 1 each: level-sensitive interrupt requests.
- `pc_s1` input 32: PC of the stage-1 instruction.
- `instruction_s1` input 32: stage-1 instruction word.
- `target_address_s1` input 32: jump/branch target.
- `data_address_s1` input 32: load/store address.
- `csr_write_enable_s1` input 1: CSR write request.
- `csr_address_s1` input 12: CSR address.
- `csr_write_data_s1` input 32: final write value, already merged for CSRRS/CSRRC.
- `csr_read_data_s1` output 32: combinational read of `csr_address_s1`.
- `global_interrupt_enable_s1` output 1: equals mstatus.MIE.
- `interrupt_pending_s1` output 1: `|(mip & mie)`.
- `trap_address_s1` output 32: combinational redirect target.

## Operation
- CSR map:
  - mstatus 0x300: MIE[3] and MPIE[7] writable. MPP[12:11] reads 2'b11. All other bits read 0.
  - misa 0x301: read-only, 32'h40000100.
  - mie 0x304: bits 11, 7, 3 writable; others read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] forced to 0 on write.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only. MEIP[11], MTIP[7], MSIP[3] are registered copies of the irq inputs.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: every register is 0 except mtvec, which resets to `RESET_MTVEC`. With all registers at reset, `global_interrupt_enable_s1` and `interrupt_pending_s1` are 0 and `csr_read_data_s1` returns the reset value of the addressed CSR.
- Cause selection, evaluated combinationally:
  - An interrupt is selected when MIE is set and `mip & mie` is nonzero. Priority: MEI (cause 0x8000000B) > MSI (0x80000003) > MTI (0x80000007).
  - Otherwise the highest-priority exception is selected:
    - illegal: cause 2, mtval = `instruction_s1`
    - misaligned instruction: cause 0, mtval = `target_address_s1`
    - ecall: cause 11, mtval = 0
    - ebreak: cause 3, mtval = 0
    - misaligned load: cause 4, mtval = `data_address_s1`
    - misaligned store: cause 6, mtval = `data_address_s1`
  - An interrupt always overrides a concurrent exception.
- Trap entry, on `take_trap_s1 & !stall_s1`:
  - mepc ← `pc_s1` with bits [1:0] cleared.
  - mcause ← selected cause.
  - mtval ← selected value; 0 for interrupts.
  - MPIE ← MIE, then MIE ← 0.
- `mret`, on `mret_s1 & !stall_s1 & !take_trap_s1`: MIE ← MPIE, MPIE ← 1.
- Simultaneous events:
  - Trap beats `mret`.
  - Trap or `mret` suppresses a CSR write in the same cycle.
  - CSR writes apply only when `csr_write_enable_s1 & !stall_s1`.
- `trap_address_s1`:
  - mepc when `mret_s1 & !take_trap_s1`.
  - Otherwise the mtvec-derived address for the selected cause.

## Timing
- CSR write, trap entry and `mret` update state on the same rising edge; the new value is readable the next cycle.
- mip samples the irq inputs every cycle, regardless of stall, so `interrupt_pending_s1` rises one cycle after an irq input rises.
- `csr_read_data_s1` and `trap_address_s1` have zero-cycle combinational latency.
- Reset mid-trap: reset wins and all state returns to reset values on that edge.

## Configuration
- `RVX_VECTORED_MTVEC_EN` defined:
  - mtvec.MODE[0] is writable; MODE[1] reads 0.
  - With MODE=1, interrupts redirect to BASE + 4×(cause[3:0]).
  - Exceptions always redirect to BASE.
- `RVX_VECTORED_MTVEC_EN` undefined:
  - mtvec[1:0] read 0 and ignore writes.
  - All traps redirect to BASE = {mtvec[31:2], 2'b00}.

## Test plan
- Reset with `RESET_MTVEC`=32'h100:
  - Read 0x305 → 32'h100.
  - Read 0x300 → 32'h1800.
  - Both interrupt outputs = 0.
- Write mie=32'hFFFFFFFF, mstatus=8, hold `irq_timer`=1:
  - Readback mie=32'h888.
  - `interrupt_pending_s1` goes to 1 one cycle after irq assertion.
  - Assert `take_trap_s1`, `pc_s1`=32'h204: mcause=32'h80000007, mepc=32'h204, mstatus=32'h1880.
- Assert `illegal_instruction_s1`, `instruction_s1`=32'hFFFFFFFF, `take_trap_s1`, with `ecall_s1` also high → mcause=2, mtval=32'hFFFFFFFF.
- After trap entry, assert `mret_s1`:
  - `trap_address_s1` = mepc.
  - Next cycle mstatus=32'h1888.
- `mret_s1`, `take_trap_s1` and a mscratch write all in one cycle → trap taken, mscratch unchanged, MIE=0.
- `RVX_VECTORED_MTVEC_EN` defined, mtvec=32'h301, MEI trap → `trap_address_s1`=32'h32C. Same setup with the macro undefined → 32'h300.
